if_id_stage: RTL

- Instruction fetch stage plus IF/ID pipeline register for the 32-bit SCU datapath.
- Holds the PC and issues one outstanding request at a time to instruction memory.
- Latches each returned instruction with its PC and pre-slices the decode fields.
- Drives the 12-bit constant and the SVPC select directly into the immediate generator, and rs/rt/rd to the register file.
- Supports downstream stall, a one-entry skid buffer, and redirect/flush from branch resolution.

---
 rtl/if_id_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the 32-bit SCU datapath.
// One outstanding imem request, a one-entry skid buffer, and redirect/flush handling.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter logic [3:0]  OP_SVPC  = 4'b1111
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [3:0]  id_opcode,
  output logic [5:0]  id_rd,
  output logic [5:0]  id_rs,
  output logic [5:0]  id_rt,
  output logic [11:0] id_const,
  output logic        id_gen
);

  typedef enum logic [1:0] {FETCH, SKID, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drainAddr_q, drainAddr_d;
  logic [31:0] skidPc_q, skidPc_d;
  logic [31:0] skidInstr_q, skidInstr_d;
  logic        idValid_q, idValid_d;
  logic [31:0] idPc_q, idPc_d;
  logic [31:0] idInstr_q, idInstr_d;
  logic        started_q;

  // started_q keeps imem_req low until the first clock after reset release
  assign imem_req  = started_q && (state_q != SKID);
  assign imem_addr = (state_q == DRAIN) ? drainAddr_q : pc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      drainAddr_q <= 32'h0;
      skidPc_q    <= 32'h0;
      skidInstr_q <= 32'h0;
      idValid_q   <= 1'b0;
      idPc_q      <= 32'h0;
      idInstr_q   <= 32'h0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drainAddr_q <= drainAddr_d;
      skidPc_q    <= skidPc_d;
      skidInstr_q <= skidInstr_d;
      idValid_q   <= idValid_d;
      idPc_q      <= idPc_d;
      idInstr_q   <= idInstr_d;
      started_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drainAddr_d = drainAddr_q;
    skidPc_d    = skidPc_q;
    skidInstr_d = skidInstr_q;
    idValid_d   = idValid_q;
    idPc_d      = idPc_q;
    idInstr_d   = idInstr_q;

    if (redirect) begin
      // Flush wins over everything; an in-flight response must still be drained
      idValid_d = 1'b0;
      pc_d      = redirect_pc;
      unique case (state_q)
        FETCH: begin
          if (imem_req && !imem_valid) begin
            state_d     = DRAIN;
            drainAddr_d = pc_q;
          end else begin
            state_d = FETCH;
          end
        end
        SKID:    state_d = FETCH;
        DRAIN:   state_d = imem_valid ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_req && imem_valid) begin
            pc_d = pc_q + PC_STEP;
            if (idValid_q && stall) begin
              skidPc_d    = pc_q;
              skidInstr_d = imem_rdata;
              state_d     = SKID;
            end else begin
              idPc_d    = pc_q;
              idInstr_d = imem_rdata;
              idValid_d = 1'b1;
            end
          end else if (!stall) begin
            idValid_d = 1'b0;
          end
        end
        SKID: begin
          if (!stall) begin
            idPc_d    = skidPc_q;
            idInstr_d = skidInstr_q;
            idValid_d = 1'b1;
            state_d   = FETCH;
          end
        end
        DRAIN: begin
          if (imem_valid) state_d = FETCH;
          if (!stall) idValid_d = 1'b0;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign id_valid  = idValid_q;
  assign id_pc     = idPc_q;
  assign id_instr  = idInstr_q;
  assign id_opcode = idInstr_q[31:28];
  assign id_rd     = idInstr_q[27:22];
  assign id_rs     = idInstr_q[21:16];
  assign id_rt     = idInstr_q[15:10];
  assign id_const  = idInstr_q[21:10];
  assign id_gen    = (idInstr_q[31:28] == OP_SVPC);

endmodule
